calc_ctrl: RTL
==============

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 clk  in  1  rising-edge system clock; the only clock.
REQ-002 n_rst  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-003 parser_done  in  1  one-cycle pulse: op/src1/src2 valid this cycle.
REQ-004 op  in  2  operator: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-005 src1, src2  in  16 each  signed two's-complement operands.
REQ-006 mul_start  out  1  one-cycle start pulse to the shared Booth multiplier (drives its parser_done).
REQ-007 mul_src1, mul_src2  out  16 each  registered operands to the multiplier.
REQ-008 mul_done  in  1  multiplier completion pulse.
REQ-009 mul_res  in  32  multiplier product, valid while mul_done=1.
REQ-010 calc_res  out  32  registered result.
REQ-011 res_valid  out  1  result available; held until accepted.
REQ-012 res_ready  in  1  consumer accepts the result when res_valid=1 and res_ready=1.
REQ-013 err  out  1  result is invalid (reserved op or multiplier timeout); valid only while res_valid=1.
REQ-014 busy  out  1  1 in every state except IDLE.
REQ-015 ovr  out  1  one-cycle pulse: parser_done arrived while busy and was dropped.
REQ-016 Parameter TIMEOUT, default 63: MWAIT cycle limit.

Function
REQ-017 The FSM SHALL have the states IDLE, DISPATCH, MWAIT and HOLD; every output is registered or decoded from the state only.
REQ-018 IDLE: on parser_done=1, latch op, src1 and src2 (src1/src2 into mul_src1/mul_src2); next state DISPATCH.
REQ-019 DISPATCH, op 00: calc_res <= sext32(src1)+sext32(src2); err <= 0; next HOLD.
REQ-020 DISPATCH, op 01: calc_res <= sext32(src1)-sext32(src2); err <= 0; next HOLD; 32-bit arithmetic, so no overflow is possible.
REQ-021 DISPATCH, op 10: mul_start=1 for exactly this cycle; clear the timeout counter; next MWAIT.
REQ-022 DISPATCH, op 11: calc_res <= 0; err <= 1; next HOLD; mul_start stays 0.
REQ-023 MWAIT: the timeout counter increments every cycle.
REQ-024 MWAIT, on mul_done=1: calc_res <= mul_res; err <= 0; next HOLD.
REQ-025 MWAIT, counter reaching TIMEOUT with mul_done=0: calc_res <= 0; err <= 1; next HOLD.
REQ-026 MWAIT, mul_done on the same cycle the counter reaches TIMEOUT: mul_done wins (err=0).
REQ-027 mul_src1/mul_src2 SHALL stay constant from DISPATCH until the exit from MWAIT, because the multiplier samples its operands throughout the operation.
REQ-028 HOLD: res_valid=1; calc_res and err stay stable.
REQ-029 HOLD, on res_ready=1: next IDLE.
REQ-030 res_ready while not in HOLD is ignored.
REQ-031 Latency: parser_done sampled at edge k gives res_valid=1 from edge k+2 for add, sub and reserved ops.
REQ-032 Latency for mul: mul_start high in cycle k+1; res_valid=1 on the edge after mul_done is sampled.
REQ-033 parser_done while busy=1 SHALL be dropped: no state or operand change; ovr=1 on the next cycle.
REQ-034 parser_done on the same edge that HOLD returns to IDLE SHALL also be dropped and flagged via ovr.
REQ-035 mul_done outside MWAIT SHALL be ignored.
REQ-036 Back-to-back operation: parser_done accepted in the first IDLE cycle after a handshake SHALL start a new operation with no bubble beyond that IDLE cycle.

Reset
REQ-037 n_rst=0 SHALL asynchronously force: state IDLE; calc_res=0; err=0; res_valid=0; busy=0; ovr=0; mul_start=0; mul_src1=0; mul_src2=0; counter=0.
REQ-038 Reset asserted mid-operation (any state) SHALL abandon the operation with no result delivered.
REQ-039 After reset is released, operation SHALL begin on the first parser_done.

Verification
REQ-040 add: src1=0x0005, src2=0xFFFD, op=00 -> calc_res=0x00000002, err=0, res_valid at k+2.
REQ-041 sub: src1=0x8000, src2=0x0001, op=01 -> calc_res=0xFFFF7FFF, err=0.
REQ-042 mul with Booth model: src1=0xFFFD, src2=0x0007 -> exactly one mul_start pulse; operands stable throughout; calc_res=0xFFFFFFEB on mul_done; res_ready held low 5 cycles -> res_valid and calc_res held stable.
REQ-043 mul with no mul_done -> after 63 MWAIT cycles: res_valid=1, err=1, calc_res=0.
REQ-044 op=11 -> err=1, calc_res=0, mul_start never asserted; a second parser_done during HOLD -> ovr pulse and the result is unchanged.
REQ-045 n_rst pulsed during MWAIT -> all outputs 0 immediately; a late mul_done after reset release is ignored.

Source files
------------

// File: rtl/calc_ctrl.sv
// ---------------------------------------------------------------------------
// calc_ctrl
//   Sequencing controller for a small calculator datapath. Accepts one
//   operation at a time from the parser, evaluates add/sub locally, hands
//   multiplies to a shared Booth multiplier (with a timeout guard), and holds
//   the result until the consumer accepts it.
//
// Ports
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   parser_done  in   one-cycle pulse, op/src1/src2 valid
//   op[1:0]      in   00 add, 01 sub, 10 mul, 11 reserved
//   src1, src2   in   16-bit signed operands
//   mul_start    out  one-cycle start pulse to the multiplier
//   mul_src1/2   out  registered operands to the multiplier
//   mul_done     in   multiplier completion pulse
//   mul_res      in   32-bit product, valid with mul_done
//   calc_res     out  registered 32-bit result
//   res_valid    out  result available, held until accepted
//   res_ready    in   consumer accept
//   err          out  result invalid (reserved op or multiplier timeout)
//   busy         out  controller is not idle
//   ovr          out  one-cycle pulse, a parser_done was dropped
// ---------------------------------------------------------------------------
module calc_ctrl #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        parser_done,
  input  logic [1:0]  op,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  output logic        mul_start,
  output logic [15:0] mul_src1,
  output logic [15:0] mul_src2,
  input  logic        mul_done,
  input  logic [31:0] mul_res,
  output logic [31:0] calc_res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        err,
  output logic        busy,
  output logic        ovr
);

  // Counter only has to reach TIMEOUT-1 before the limit fires.
  localparam int CntWidth = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    MWAIT    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t              state_q;
  logic [1:0]          op_q;
  logic [15:0]         src1_q;
  logic [15:0]         src2_q;
  logic                mulStart_q;
  logic [31:0]         calcRes_q;
  logic                resValid_q;
  logic                err_q;
  logic                busy_q;
  logic                ovr_q;
  logic [CntWidth-1:0] cnt_q;

  logic [31:0]         dispRes_d;
  logic                dispErr_d;

  // Result of the locally evaluated operators, computed from the latched
  // operands so the DISPATCH state only has to pick it up. Operands are
  // sign-extended first, so the 32-bit sum/difference can never overflow.
  always_comb begin
    dispRes_d = 32'd0;
    dispErr_d = 1'b0;
    case (op_q)
      2'b00:   dispRes_d = {{16{src1_q[15]}}, src1_q} + {{16{src2_q[15]}}, src2_q};
      2'b01:   dispRes_d = {{16{src1_q[15]}}, src1_q} - {{16{src2_q[15]}}, src2_q};
      2'b11:   dispErr_d = 1'b1;
      default: dispErr_d = 1'b0;
    endcase
  end

  // Main controller. All outputs are registered here alongside the state.
  // busy/res_valid are written together with every state change so they
  // always reflect the state being entered. A parser_done seen outside IDLE
  // (including the HOLD cycle that is handing back to IDLE) is dropped and
  // flagged on ovr the following cycle. The multiplier operands are only
  // written on acceptance, so they stay put for the whole multiply.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      src1_q     <= 16'd0;
      src2_q     <= 16'd0;
      mulStart_q <= 1'b0;
      calcRes_q  <= 32'd0;
      resValid_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mulStart_q <= 1'b0;
      ovr_q      <= parser_done && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (parser_done) begin
            op_q       <= op;
            src1_q     <= src1;
            src2_q     <= src2;
            mulStart_q <= (op == 2'b10);
            busy_q     <= 1'b1;
            state_q    <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (op_q == 2'b10) begin
            cnt_q   <= '0;
            state_q <= MWAIT;
          end else begin
            calcRes_q  <= dispRes_d;
            err_q      <= dispErr_d;
            resValid_q <= 1'b1;
            state_q    <= HOLD;
          end
        end
        MWAIT: begin
          cnt_q <= cnt_q + CntWidth'(1);
          // A completion on the limit cycle still counts as success.
          if (mul_done) begin
            calcRes_q  <= mul_res;
            err_q      <= 1'b0;
            resValid_q <= 1'b1;
            state_q    <= HOLD;
          end else if (cnt_q == CntLast) begin
            calcRes_q  <= 32'd0;
            err_q      <= 1'b1;
            resValid_q <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            resValid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_start = mulStart_q;
  assign mul_src1  = src1_q;
  assign mul_src2  = src2_q;
  assign calc_res  = calcRes_q;
  assign res_valid = resValid_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign ovr       = ovr_q;

endmodule
